poly_add_ctrl: RTL
==================

# poly_add_ctrl

Sequencer that streams two coefficient banks through one `mod_add` instance and writes the coefficient-wise modular sum back to memory. After one start pulse it walks addresses `0..N_COEFF-1` at one coefficient per cycle, with a read–add–write pipeline of two stages. It sits in the PE between the coefficient RAMs and the arithmetic datapath and owns all address and enable generation for vector add (and optionally subtract) jobs.

## Interface
- `N_COEFF`, 256, coefficients per job; must be ≥1 and ≤2^AW.
- `AW`, 8, address width.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: job request, sampled only in IDLE.
- `q_i` in 23: modulus, captured at job start.
- `sub_i` in 1: 1 selects A−B mod q. The port exists only with POLY_SUB_EN.
- `busy_o` out 1: job in progress.
- `done_o` out 1: one-cycle completion pulse.
- `rd_en_o` out 1: read strobe to both banks.
- `rd_addr_o` out AW: read address, shared by both banks.
- `a_rdata_i` in 23: bank A data, valid one cycle after `rd_en_o`.
- `b_rdata_i` in 23: bank B data, valid one cycle after `rd_en_o`.
- `wr_en_o` out 1: result write strobe.
- `wr_addr_o` out AW: result address.
- `wr_data_o` out 23: result value.

## Operation
- FSM states and transitions:
  - IDLE: moves to RUN on `start_i`.
  - RUN: moves to DRAIN after issuing address N_COEFF−1.
  - DRAIN: lasts 2 cycles, flushing the pipeline, then moves to DONE.
  - DONE: lasts 1 cycle, then moves to IDLE.
- On start, `q_i` is latched into `q_r`, and `sub_i` into `sub_r` when POLY_SUB_EN is defined. Changes to the inputs mid-job have no effect.
- Address counter: 0 to N_COEFF−1, one per RUN cycle. It does not wrap within a job and is cleared to 0 on entering RUN.
- Stage 1: the read is issued with `rd_en_o=1` and `rd_addr_o=k`. A registered valid bit `v1` and address `a1=k` follow it.
- Stage 2: when `v1=1`, `a_rdata_i`, `b_rdata_i` and `q_r` drive `mod_add`, which is combinational.
- Stage 2 outputs are registered: `c_o` into `wr_data_o`, `a1` into `wr_addr_o`, and `v1` into `wr_en_o`.
- Operand rules:
  - Operands must be < q. Behaviour for operands ≥ q is unspecified and is not checked.
  - The 23-bit operands are zero-extended to the 24-bit `mod_add` inputs.
  - The result is always in [0, q−1].
- `start_i` outside IDLE is ignored and is not queued.
- `rst_i` at any cycle, including mid-RUN or DRAIN:
  - The next cycle is IDLE.
  - All outputs are 0 and pipeline valids are cleared.
  - No further write is issued for the aborted job.

## Timing
- Reset values: `busy_o`, `done_o`, `rd_en_o`, `wr_en_o` = 0; `rd_addr_o`, `wr_addr_o`, `wr_data_o` = 0.
- Cycle numbering: start is sampled at edge E0, and cycle c is the c-th cycle after E0.
- `rd_en_o`=1 in cycles 1..N_COEFF, with `rd_addr_o`=c−1.
- Read data is valid in cycles 2..N_COEFF+1.
- `wr_en_o`=1 in cycles 3..N_COEFF+2, with `wr_addr_o`=c−3.
- Latency is 2 cycles from read issue to write; throughput is 1 coefficient per cycle.
- `busy_o`=1 in cycles 1..N_COEFF+2.
- `done_o`=1 in cycle N_COEFF+3 only, with `busy_o`=0 in that cycle.
- The earliest next start is sampled at the end of cycle N_COEFF+4, once the FSM is back in IDLE. This gives a job period of N_COEFF+4 cycles.
- N_COEFF=1 still follows the full RUN, DRAIN, DONE sequence.

## Configuration
- Macro: `POLY_SUB_EN`.
- When defined:
  - The `sub_i` port exists.
  - With `sub_r=1`, the B operand is replaced by `(b==0) ? 0 : q_r−b` before `mod_add`, so the block computes (a−b) mod q.
  - The negation mux is combinational in stage 2 and does not change latency.
- When undefined: no `sub_i` port and no mux; the block always computes (a+b) mod q.

## Structure
- The shared package `pe_pkg` holds:
  - `COEFF_W=23` and `MOD_IN_W=24`.
  - The FSM enum `poly_add_state_t` (IDLE, RUN, DRAIN, DONE).
  - The default-modulus constant `Q_DILITHIUM=23'd8380417` for benches.
- Sub-module: the existing `mod_add`, instantiated once. All other logic is flat in `poly_add_ctrl`.

## Test plan
- Basic add: N_COEFF=4, q=8380417, A=[5,8380416,0,4190208], B=[7,1,0,4190209] → writes [12,0,0,0] to addresses 0..3 in cycles 3..6; `done_o` in cycle 7.
- Timing check: N_COEFF=256 with random A,B<q → exactly 256 writes with ascending `wr_addr_o` and no gaps; `busy_o` high for 258 cycles; one `done_o` pulse.
- Start during busy: pulse `start_i` in cycle 5 of a running job → no second job; the write count stays N_COEFF.
- Reset mid-job: assert `rst_i` in cycle 10 → from cycle 11 all outputs are 0; no writes after that; a new start afterwards runs a clean job from address 0.
- q change mid-job: q_i=8380417 at start, changed to 17 in cycle 4 → all results are still mod 8380417.
- POLY_SUB_EN: sub_i=1, A=[3,0,100], B=[5,0,100], q=8380417 → [8380415,0,0]; with sub_i=0 the same vectors give [8,0,200].

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared PE widths, FSM state type and default modulus.
package pe_pkg;
  localparam int COEFF_W = 23;
  localparam int MOD_IN_W = 24;
  localparam logic [COEFF_W-1:0] Q_DILITHIUM = 23'd8380417;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} poly_add_state_t;
endpackage

// File: rtl/poly_add_ctrl_if.sv
// poly_add_ctrl_if: job control, bank read and result write signals of poly_add_ctrl.
// slave = controller side, master = RAM/host side; sub_i exists only with POLY_SUB_EN.
interface poly_add_ctrl_if import pe_pkg::*; #(parameter int AW = 8);
  logic start_i;
  logic [COEFF_W-1:0] q_i;
`ifdef POLY_SUB_EN
  logic sub_i;
`endif
  logic busy_o;
  logic done_o;
  logic rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [COEFF_W-1:0] a_rdata_i;
  logic [COEFF_W-1:0] b_rdata_i;
  logic wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [COEFF_W-1:0] wr_data_o;
  modport slave (
    input start_i, q_i, a_rdata_i, b_rdata_i,
`ifdef POLY_SUB_EN
    input sub_i,
`endif
    output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
  modport master (
    output start_i, q_i, a_rdata_i, b_rdata_i,
`ifdef POLY_SUB_EN
    output sub_i,
`endif
    input busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/mod_add.sv
// mod_add: combinational (a + b) mod q for operands already below q.
// Ports: a_i, b_i, q_i operands/modulus; c_o result in [0, q-1].
module mod_add import pe_pkg::*; (
  input  logic [MOD_IN_W-1:0] a_i,
  input  logic [MOD_IN_W-1:0] b_i,
  input  logic [MOD_IN_W-1:0] q_i,
  output logic [MOD_IN_W-1:0] c_o
);
  logic [MOD_IN_W:0] s;
  assign s = {1'b0, a_i} + {1'b0, b_i};
  assign c_o = (s >= {1'b0, q_i}) ? MOD_IN_W'(s - {1'b0, q_i}) : s[MOD_IN_W-1:0];
endmodule

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: streams banks A and B through mod_add and writes (a+b) mod q back, one coefficient per cycle.
// Ports: clk_i, rst_i (sync, active high); bus (poly_add_ctrl_if.slave) carries start/q, bank reads and result writes.
// Macro POLY_SUB_EN adds sub_i and a stage-2 negation mux so the block computes (a-b) mod q.
module poly_add_ctrl import pe_pkg::*; #(
  parameter int N_COEFF = 256,
  parameter int AW = 8
) (
  input logic clk_i,
  input logic rst_i,
  poly_add_ctrl_if.slave bus
);
  localparam logic [AW-1:0] LAST = AW'(N_COEFF - 1);
  poly_add_state_t state, state_n;
  logic [AW-1:0] cnt, a1;
  logic d, v1;
  logic [COEFF_W-1:0] q_r, b_op;
  logic [MOD_IN_W-1:0] c;
`ifdef POLY_SUB_EN
  logic sub_r;
  assign b_op = !sub_r ? bus.b_rdata_i : (bus.b_rdata_i == '0) ? '0 : q_r - bus.b_rdata_i;
`else
  assign b_op = bus.b_rdata_i;
`endif
  mod_add u_mod_add (
    .a_i({1'b0, bus.a_rdata_i}),
    .b_i({1'b0, b_op}),
    .q_i({1'b0, q_r}),
    .c_o(c)
  );
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  // d marks the second DRAIN cycle, after which the last write has left stage 2
  always_comb begin
    state_n = (state == IDLE && bus.start_i) ? RUN :
              (state == RUN && cnt == LAST) ? DRAIN :
              (state == DRAIN && d) ? DONE :
              (state == DONE) ? IDLE : state;
    bus.rd_en_o = state == RUN;
    bus.rd_addr_o = (state == RUN) ? cnt : '0;
    bus.busy_o = state == RUN || state == DRAIN;
    bus.done_o = state == DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      d <= 1'b0;
      v1 <= 1'b0;
      a1 <= '0;
      q_r <= '0;
      bus.wr_en_o <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
`ifdef POLY_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE) ? '0 : (state == RUN && cnt != LAST) ? cnt + 1'b1 : cnt;
      d <= state == DRAIN && !d;
      v1 <= state == RUN;
      a1 <= cnt;
      bus.wr_en_o <= v1;
      if (v1) begin
        bus.wr_addr_o <= a1;
        bus.wr_data_o <= COEFF_W'(c);
      end
      if (state == IDLE && bus.start_i) begin
        q_r <= bus.q_i;
`ifdef POLY_SUB_EN
        sub_r <= bus.sub_i;
`endif
      end
    end
  end
endmodule
